uart_rx_fifo: RTL and testbench

//   Downstream consumer of the UART receiver. Captures each byte flagged by the receiver's

---
 rtl/uart_rx_fifo_if.sv | 26 ++
 rtl/uart_rx_fifo.sv | 107 ++++++++++
 tb/tb_uart_rx_fifo.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Byte-receive handshake and host read port between the UART receiver, the RX FIFO and the host.
interface uart_rx_fifo_if #(
   parameter int ADDR_W = 4
);
   logic              rx_ready;
   logic [7:0]        rx_data;
   logic              rx_ready_clr;
   logic              rd_en;
   logic [7:0]        rd_data;
   logic              rd_valid;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              overrun;
   logic              overrun_clr;

   modport slave (
      input  rx_ready, rx_data, rd_en, overrun_clr,
      output rx_ready_clr, rd_data, rd_valid, empty, full, count, overrun
   );

   modport master (
      output rx_ready, rx_data, rd_en, overrun_clr,
      input  rx_ready_clr, rd_data, rd_valid, empty, full, count, overrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Acknowledges bytes from the UART receiver and buffers them in a DEPTH-entry FIFO
// with a registered host read port and a sticky overrun flag.
module uart_rx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic            clk_50m,
   input  logic            rst_n,
   uart_rx_fifo_if.slave   bus
);
   localparam logic [0:0]      S_IDLE  = 1'b0;
   localparam logic [0:0]      S_ACK   = 1'b1;
   localparam logic [ADDR_W:0] L_DEPTH = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W-1:0] L_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_ready_clr;
   logic [7:0]        r_rd_data;
   logic              r_rd_valid;
   logic              r_overrun;
   logic [7:0]        r_mem [0:DEPTH-1];

   logic w_empty;
   logic w_full;
   logic w_take;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == L_DEPTH);
   assign w_pop   = bus.rd_en & ~w_empty;
   // A byte is taken exactly once: only from IDLE, the ACK state waits for ready to fall.
   assign w_take  = (r_state == S_IDLE) & bus.rx_ready;
   assign w_push  = w_take & (~w_full | w_pop);
   assign w_drop  = w_take & w_full & ~w_pop;

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ready_clr <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.rx_ready) begin
                  r_ready_clr <= 1'b0;
                  r_state     <= S_ACK;
               end
            end
            S_ACK: begin
               if (!bus.rx_ready) begin
                  r_ready_clr <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_ready_clr <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_data  <= 8'h00;
         r_rd_valid <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_rd_valid <= w_pop;
         if (w_pop) begin
            r_rd_data <= r_mem[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + L_PTR_ONE;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
         end
         r_count <= r_count + {{ADDR_W{1'b0}}, w_push} - {{ADDR_W{1'b0}}, w_pop};
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (bus.overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   // Storage is not reset; on a full push+pop the read sees the old entry before overwrite.
   always_ff @(posedge clk_50m) begin
      if (rst_n && w_push) begin
         r_mem[r_wr_ptr] <= bus.rx_data;
      end
   end

   assign bus.rx_ready_clr = r_ready_clr;
   assign bus.rd_data      = r_rd_data;
   assign bus.rd_valid     = r_rd_valid;
   assign bus.empty        = w_empty;
   assign bus.full         = w_full;
   assign bus.count        = r_count;
   assign bus.overrun      = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios plus a randomized phase checked
// against a queue-based model of the FIFO and overrun flag.
module tb_uart_rx_fifo;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic clk_50m = 1'b0;
   logic rst_n   = 1'b0;

   uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus();

   uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #10 clk_50m = ~clk_50m;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  model_q[$];
   logic [7:0]  exp_q[$];
   bit          model_ovr = 1'b0;
   logic [7:0]  mon_exp;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every rd_valid pulse must match the oldest outstanding expected read.
   always @(negedge clk_50m) begin
      if (rst_n && bus.rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rd_valid_unexpected: rd_data=%0h, expected no read", bus.rd_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (bus.rd_data !== mon_exp) begin
               failures++;
               $display("FAIL rd_data: got %0h, expected %0h at %0t", bus.rd_data, mon_exp, $time);
            end
         end
      end
   end

   task automatic check_status();
      chk("count",   int'(bus.count),   model_q.size());
      chk("empty",   int'(bus.empty),   int'(model_q.size() == 0));
      chk("full",    int'(bus.full),    int'(model_q.size() == DEPTH));
      chk("overrun", int'(bus.overrun), int'(model_ovr));
   endtask

   task automatic send(input logic [7:0] d, input bit pop_too, input bit clr, input int hold);
      bit was_full;
      bit was_empty;
      bit popped;
      @(negedge clk_50m);
      bus.rx_ready    = 1'b1;
      bus.rx_data     = d;
      bus.rd_en       = pop_too;
      bus.overrun_clr = clr;
      @(posedge clk_50m);
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      popped    = pop_too && !was_empty;
      if (popped) exp_q.push_back(model_q.pop_front());
      if (!was_full || popped) begin
         model_q.push_back(d);
         if (clr) model_ovr = 1'b0;
      end else begin
         model_ovr = 1'b1;
      end
      @(negedge clk_50m);
      bus.rd_en       = 1'b0;
      bus.overrun_clr = 1'b0;
      chk("rx_ready_clr_low", int'(bus.rx_ready_clr), 0);
      if (pop_too && was_empty) chk("rd_valid_empty_pop", int'(bus.rd_valid), 0);
      check_status();
      for (int h = 0; h < hold; h++) begin
         @(negedge clk_50m);
         chk("rx_ready_clr_hold", int'(bus.rx_ready_clr), 0);
         chk("count_hold", int'(bus.count), model_q.size());
      end
      bus.rx_ready = 1'b0;
      @(negedge clk_50m);
      chk("rx_ready_clr_release", int'(bus.rx_ready_clr), 1);
      check_status();
   endtask

   task automatic pop();
      @(negedge clk_50m);
      bus.rd_en = 1'b1;
      @(posedge clk_50m);
      if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
      @(negedge clk_50m);
      bus.rd_en = 1'b0;
      check_status();
   endtask

   task automatic clear_ovr();
      @(negedge clk_50m);
      bus.overrun_clr = 1'b1;
      @(posedge clk_50m);
      model_ovr = 1'b0;
      @(negedge clk_50m);
      bus.overrun_clr = 1'b0;
      check_status();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      bus.rx_ready    = 1'b0;
      bus.rx_data     = 8'h00;
      bus.rd_en       = 1'b0;
      bus.overrun_clr = 1'b0;
      rst_n           = 1'b0;
      repeat (3) @(negedge clk_50m);
      chk("reset_rx_ready_clr", int'(bus.rx_ready_clr), 1);
      chk("reset_rd_data",      int'(bus.rd_data),      0);
      chk("reset_rd_valid",     int'(bus.rd_valid),     0);
      check_status();
      rst_n = 1'b1;

      // Single byte, ready held two extra cycles.
      send(8'hA5, 1'b0, 1'b0, 2);
      pop();

      // Fill, overflow, drain.
      for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0, 1'b0, 0);
      send(8'hFF, 1'b0, 1'b0, 0);
      for (int i = 0; i < DEPTH; i++) pop();
      clear_ovr();

      // Pointer wrap.
      v = 8'h20;
      for (int i = 0; i < 10; i++) begin send(v, 1'b0, 1'b0, 0); v++; end
      for (int i = 0; i < 10; i++) pop();
      for (int i = 0; i < 12; i++) begin send(v, 1'b0, 1'b0, 0); v++; end
      for (int i = 0; i < 12; i++) pop();

      // Push and pop together when full, then when empty.
      for (int i = 0; i < DEPTH; i++) send(8'h80 + 8'(i), 1'b0, 1'b0, 0);
      send(8'h55, 1'b1, 1'b0, 0);
      for (int i = 0; i < DEPTH; i++) pop();
      send(8'h3C, 1'b1, 1'b0, 0);
      pop();

      // Overrun clear collides with a drop, then clears alone.
      for (int i = 0; i < DEPTH; i++) send(8'(i * 3), 1'b0, 1'b0, 0);
      send(8'hEE, 1'b0, 1'b0, 0);
      send(8'hEF, 1'b0, 1'b1, 0);
      clear_ovr();
      for (int i = 0; i < DEPTH; i++) pop();

      // Reset while acknowledging a byte the receiver still holds.
      @(negedge clk_50m);
      bus.rx_ready = 1'b1;
      bus.rx_data  = 8'h77;
      @(posedge clk_50m);
      model_q.push_back(8'h77);
      @(negedge clk_50m);
      rst_n = 1'b0;
      @(posedge clk_50m);
      model_q.delete();
      model_ovr = 1'b0;
      @(negedge clk_50m);
      chk("rst_mid_ack_clr", int'(bus.rx_ready_clr), 1);
      check_status();
      rst_n = 1'b1;
      @(posedge clk_50m);
      model_q.push_back(8'h77);
      @(negedge clk_50m);
      chk("recapture_clr_low", int'(bus.rx_ready_clr), 0);
      check_status();
      bus.rx_ready = 1'b0;
      @(negedge clk_50m);
      chk("recapture_clr_release", int'(bus.rx_ready_clr), 1);
      check_status();
      pop();

      // Randomized traffic.
      for (int n = 0; n < 250; n++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op <= 4)
            send(8'($urandom), bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 5) == 0),
                 $urandom_range(0, 2));
         else if (op <= 8)
            pop();
         else
            clear_ovr();
      end
      while (model_q.size() > 0) pop();

      repeat (3) @(negedge clk_50m);
      chk("pending_reads", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
